// File: rtl/xalu_pkg.sv
// Shared definitions for the multi-nibble ALU sequencer and its 4-bit slice.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package xalu_pkg;

  // Function codes, identical to the 4-bit slice encoding.
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_SHL   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xalu_slice.sv
// Combinational 4-bit ALU slice: one nibble of ADD/logic/pass/shift with optional 1's complement.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: da/db operand nibbles, f function code, com complement, ci_left/ci_right carry/shift in,
//        d result nibble, co_left/co_right carry/shift out, equ (da == db).
module xalu_slice
  import xalu_pkg::*;
(
  input  logic [3:0] da,
  input  logic [3:0] db,
  input  logic [2:0] f,
  input  logic       com,
  input  logic       ci_left,
  input  logic       ci_right,
  output logic [3:0] d,
  output logic       co_left,
  output logic       co_right,
  output logic       equ
);

  logic [4:0] sum;
  logic [3:0] r;

  always_comb begin
    sum      = {1'b0, da} + {1'b0, db} + {4'b0000, ci_right};
    r        = 4'h0;
    co_left  = 1'b0;
    co_right = 1'b0;
    case (f)
      OP_ADD:   begin r = sum[3:0]; co_left = sum[4]; end
      OP_AND:   r = da & db;
      OP_OR:    r = da | db;
      OP_XOR:   r = da ^ db;
      OP_PASSA: r = da;
      OP_PASSB: r = db;
      // Right shift: bit enters at the top, bit 0 leaves towards the lower nibble.
      OP_SHR:   begin r = {ci_left, da[3:1]}; co_right = da[0]; end
      // Left shift: bit enters at the bottom, bit 3 leaves towards the upper nibble.
      OP_SHL:   begin r = {da[2:0], ci_right}; co_left = da[3]; end
      default:  r = da;
    endcase
    // Complement touches the data nibble only; carries above stay pre-complement.
    d   = com ? ~r : r;
    equ = (da == db);
  end

endmodule

// File: rtl/xalu_seq.sv
// Runs WIDTH-bit ALU operations through one 4-bit slice, one nibble per clock, with status flags.
// Latency: start sampled at edge t, done pulses in the cycle after edge t+NIB+1 (5 cycles at WIDTH=16).
// Backpressure: start accepted only in IDLE; start while busy is dropped, nothing is queued.
// Ports: clk, rst_n (sync active-low); start/op/com/a/b/cin request; busy, done, result, cout,
//        zero, neg_zero, equ status (result and flags registered, held between operations).
module xalu_seq
  import xalu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             com,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg_zero,
  output logic             equ
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("xalu_seq: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic [2:0]       op_q;
  logic             com_q, carry_q, carry_next, fin_q, equ_acc_q;
  logic [CW-1:0]    cnt_q, idx;
  logic [CW+1:0]    base;
  logic [3:0]       s_d;
  logic             s_co_left, s_co_right, s_equ;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q, neg_q, equ_q;

  // SHR walks MSB nibble first so the shift bit travels downwards; everything else walks up.
  assign idx  = (op_q == OP_SHR) ? (CW'(NIB - 1) - cnt_q) : cnt_q;
  assign base = {idx, 2'b00};

  xalu_slice u_slice (
    .da       (a_q[base +: 4]),
    .db       (b_q[base +: 4]),
    .f        (op_q),
    .com      (com_q),
    .ci_left  (carry_q),
    .ci_right (carry_q),
    .d        (s_d),
    .co_left  (s_co_left),
    .co_right (s_co_right),
    .equ      (s_equ)
  );

  assign carry_next = (op_q == OP_SHR) ? s_co_right : s_co_left;

  always_comb begin
    acc_next             = acc_q;
    acc_next[base +: 4]  = s_d;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. RUN spends NIB nibble cycles plus one commit cycle (fin_q set).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (fin_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Datapath: capture, per-nibble accumulation, and commit of result/flags on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      com_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      fin_q     <= 1'b0;
      acc_q     <= '0;
      equ_acc_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      equ_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            op_q      <= op;
            com_q     <= com;
            carry_q   <= cin;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            acc_q     <= '0;
            equ_acc_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!fin_q) begin
            acc_q     <= acc_next;
            carry_q   <= carry_next;
            equ_acc_q <= equ_acc_q & s_equ;
            // Counter parks on the terminal value; only a new start clears it.
            if (cnt_q == CW'(NIB - 1)) fin_q <= 1'b1;
            else                       cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= acc_q;
            cout_q   <= carry_q;
            zero_q   <= (acc_q == '0);
            neg_q    <= (&acc_q);
            equ_q    <= equ_acc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign neg_zero = neg_q;
  assign equ      = equ_q;

endmodule

// File: tb/tb_xalu_seq.sv
// Bench for xalu_seq: directed vector table, random ops against a word-level model, and
// multi-cycle sequences (ignored start, back-to-back, reset mid-run, WIDTH=8 instance).
module tb_xalu_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start, com, cin;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done, cout, zero, neg_zero, equ;
  logic [15:0] result;

  logic        start8, com8, cin8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, zero8, neg_zero8, equ8;
  logic [7:0]  result8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  xalu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .neg_zero(neg_zero), .equ(equ)
  );

  xalu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .com(com8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .zero(zero8),
    .neg_zero(neg_zero8), .equ(equ8)
  );

  typedef struct {
    logic [2:0]  op;
    logic        com;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        equ;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Word-level reference: whole-operand arithmetic, no nibble stepping.
  function automatic logic [19:0] model(input logic [2:0] o, input logic c,
                                        input logic [15:0] aa, input logic [15:0] bb,
                                        input logic ci);
    logic [16:0] s;
    logic [15:0] r;
    logic        co;
    s  = {1'b0, aa} + {1'b0, bb} + 17'(ci);
    r  = aa;
    co = 1'b0;
    case (o)
      3'd0: begin r = s[15:0]; co = s[16]; end
      3'd1: r = aa & bb;
      3'd2: r = aa | bb;
      3'd3: r = aa ^ bb;
      3'd4: r = aa;
      3'd5: r = bb;
      3'd6: begin r = {ci, aa[15:1]}; co = aa[0]; end
      default: begin r = {aa[14:0], ci}; co = aa[15]; end
    endcase
    if (c) r = ~r;
    return {r, co, (r == 16'h0000), (r == 16'hFFFF), (aa == bb)};
  endfunction

  task automatic run16(input logic [2:0] o, input logic c, input logic [15:0] aa,
                       input logic [15:0] bb, input logic ci, output int lat);
    op = o; com = c; a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: only captured copies may matter.
    start = 1'b0; op = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
    a = 16'($urandom); b = 16'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic do_op(input string nm, input logic [2:0] o, input logic c,
                       input logic [15:0] aa, input logic [15:0] bb, input logic ci,
                       input logic [19:0] exp);
    int lat;
    run16(o, c, aa, bb, ci, lat);
    check({nm, " latency"}, 64'(lat), 64'd5);
    check({nm, " outputs"}, 64'({result, cout, zero, neg_zero, equ}), 64'(exp));
    @(posedge clk); #1;
    check({nm, " done width"}, 64'(done), 64'd0);
  endtask

  task automatic do_op8(input string nm, input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ci, input logic [11:0] exp);
    int lat;
    op8 = o; com8 = 1'b0; a8 = aa; b8 = bb; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done8) break;
    end
    check({nm, " latency"}, 64'(lat), 64'd3);
    check({nm, " outputs"}, 64'({result8, cout8, zero8, neg_zero8, equ8}), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone;
    logic [15:0] ra, rb;
    logic [2:0]  ro;
    logic        rc, rci;

    //           op    com a        b        cin  res      cout zero neg equ
    tbl[0]  = '{3'd0, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1, 0, 0};
    tbl[1]  = '{3'd6, 0, 16'h8001, 16'h0000, 1, 16'hC000, 1, 0, 0, 0};
    tbl[2]  = '{3'd7, 0, 16'h8001, 16'h0000, 0, 16'h0002, 1, 0, 0, 0};
    tbl[3]  = '{3'd3, 1, 16'h1234, 16'h1234, 0, 16'hFFFF, 0, 0, 1, 1};
    tbl[4]  = '{3'd0, 1, 16'h7FFF, 16'h0001, 0, 16'h7FFF, 0, 0, 0, 0};
    tbl[5]  = '{3'd1, 0, 16'hF0F0, 16'h3C3C, 0, 16'h3030, 0, 0, 0, 0};
    tbl[6]  = '{3'd2, 1, 16'h00F0, 16'h0F00, 0, 16'hF00F, 0, 0, 0, 0};
    tbl[7]  = '{3'd5, 0, 16'h1111, 16'hABCD, 1, 16'hABCD, 0, 0, 0, 0};
    tbl[8]  = '{3'd4, 1, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, 1, 1};
    tbl[9]  = '{3'd0, 0, 16'h1234, 16'h1111, 1, 16'h2346, 0, 0, 0, 0};
    tbl[10] = '{3'd6, 1, 16'h0001, 16'h0001, 0, 16'hFFFF, 1, 0, 1, 1};
    tbl[11] = '{3'd7, 0, 16'h4000, 16'h0000, 1, 16'h8001, 0, 0, 0, 0};

    rst_n = 1'b0; start = 1'b0; op = '0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; com8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset16", 64'({busy, done, result, cout, zero, neg_zero, equ}), 64'd0);
    check("reset8", 64'({busy8, done8, result8, cout8, zero8, neg_zero8, equ8}), 64'd0);
    rst_n = 1'b1;

    // Directed table; consecutive calls also exercise start in the IDLE cycle right after DONE.
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].com, tbl[i].a, tbl[i].b, tbl[i].cin,
            {tbl[i].res, tbl[i].cout, tbl[i].zero, tbl[i].neg, tbl[i].equ});
    end

    // Random operations against the word-level model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom); rc = 1'($urandom); rci = 1'($urandom);
      ra = 16'($urandom); rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      do_op($sformatf("rand%0d", i), ro, rc, ra, rb, rci, model(ro, rc, ra, rb, rci));
    end

    // start while busy must be ignored.
    op = 3'd0; com = 1'b0; a = 16'h0102; b = 16'h0304; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd3; a = 16'hFFFF; b = 16'h0000; cin = 1'b1; start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) start = 1'b0;
      if (done) break;
    end
    check("ignored start latency", 64'(lat), 64'd5);
    check("ignored start outputs", 64'({result, cout, zero, neg_zero, equ}),
          64'(model(3'd0, 1'b0, 16'h0102, 16'h0304, 1'b0)));
    @(posedge clk); #1;
    check("ignored start no second done", 64'({busy, done}), 64'd0);

    // Reset in the second RUN cycle aborts cleanly.
    op = 3'd0; com = 1'b0; a = 16'h1000; b = 16'h2000; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort outputs", 64'({busy, done, result, cout, zero, neg_zero, equ}), 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    do_op("after abort", 3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0,
          model(3'd0, 1'b0, 16'h00FF, 16'h0001, 1'b0));

    // WIDTH=8 instance.
    do_op8("w8 add", 3'd0, 8'h0F, 8'h01, 1'b0, {8'h10, 1'b0, 1'b0, 1'b0, 1'b0});
    do_op8("w8 carry", 3'd0, 8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
    do_op8("w8 shl", 3'd7, 8'h81, 8'h81, 1'b1, {8'h03, 1'b1, 1'b0, 1'b0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
